// File: rtl/response_checker_if.sv
// Response handshake between the stimulus/DUT side and the response checker:
// one observed vector plus its expected value and case index per accepted beat.
interface response_checker_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2
);
    logic             vec_valid;
    logic             vec_ready;
    logic [IN_W-1:0]  vec_idx;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] exp_out;

    modport master (
        output vec_valid,
        output vec_idx,
        output dut_out,
        output exp_out,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_idx,
        input  dut_out,
        input  exp_out,
        output vec_ready
    );
endinterface

// File: rtl/response_checker.sv
// Consumes one response vector per handshake, compares it to its expected value,
// tracks the case sequence and raises a pass/fail verdict once every case is seen.
module response_checker #(
    parameter int IN_W      = 3,
    parameter int OUT_W     = 2,
    parameter int NUM_CASES = 8,
    parameter int CNT_W     = $clog2(NUM_CASES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    response_checker_if.slave vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  case_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [IN_W-1:0]   first_err_idx,
    output logic              seq_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CASES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;
    state_t state_next;

    logic accept;
    logic idx_bad;
    logic data_bad;
    logic fail;
    logic last;

    // start outranks a same-cycle vector, so a restart never counts that beat.
    always_comb begin
        accept   = (state == S_RUN) && vec.vec_valid && !start;
        idx_bad  = (vec.vec_idx != IN_W'(case_count));
        // NOTE: case-inequality makes X/Z on dut_out a mismatch in simulation;
        // synthesis sees an ordinary inequality.
        data_bad = (vec.dut_out !== vec.exp_out);
        fail     = idx_bad || data_bad;
        last     = ((case_count + CNT_ONE) == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        vec.vec_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy          = 1'b1;
                vec.vec_ready = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                end else if (accept && last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counters, sticky flags and the verdict; start from any state begins a fresh run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            case_count      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            seq_err         <= 1'b0;
            pass            <= 1'b0;
        end else if (start) begin
            case_count      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            seq_err         <= 1'b0;
            pass            <= 1'b0;
        end else if (accept) begin
            case_count <= case_count + CNT_ONE;
            if (idx_bad) begin
                seq_err <= 1'b1;
            end
            if (fail) begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_ONE;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= vec.vec_idx;
                end
            end
            if (last) begin
                pass <= !fail && (err_count == '0) && !seq_err;
            end
        end
    end

endmodule

// File: tb/tb_response_checker.sv
// Scoreboard bench for response_checker: a reference model predicts the full
// status after every driven cycle and the prediction is compared one edge later.
module tb_response_checker;

    localparam int IN_W      = 3;
    localparam int OUT_W     = 2;
    localparam int NUM_CASES = 8;
    localparam int CNT_W     = 4;

    localparam logic [23:0] ORD_LIN  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] ORD_SWAP = {3'd7, 3'd6, 3'd5, 3'd3, 3'd4, 3'd2, 3'd1, 3'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] case_count;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [IN_W-1:0]  first_err_idx;
    logic             seq_err;

    response_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W)) vif ();

    response_checker #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .NUM_CASES(NUM_CASES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .vec(vif),
        .busy(busy),
        .done(done),
        .pass(pass),
        .case_count(case_count),
        .err_count(err_count),
        .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] err;
        logic             fev;
        logic [IN_W-1:0]  fei;
        logic             seq;
        logic             busy;
        logic             done;
        logic             pass;
        logic             rdy;
    } snap_t;

    snap_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference model state: 0 idle, 1 run, 2 done.
    int               m_state = 0;
    logic [CNT_W-1:0] m_cnt   = '0;
    logic [CNT_W-1:0] m_err   = '0;
    logic             m_fev   = 1'b0;
    logic [IN_W-1:0]  m_fei   = '0;
    logic             m_seq   = 1'b0;
    logic             m_pass  = 1'b0;

    function automatic snap_t model_snap();
        snap_t s;
        s.cnt  = m_cnt;
        s.err  = m_err;
        s.fev  = m_fev;
        s.fei  = m_fei;
        s.seq  = m_seq;
        s.busy = (m_state == 1);
        s.done = (m_state == 2);
        s.pass = m_pass;
        s.rdy  = (m_state == 1);
        return s;
    endfunction

    function automatic snap_t observed();
        snap_t s;
        s.cnt  = case_count;
        s.err  = err_count;
        s.fev  = first_err_valid;
        s.fei  = first_err_idx;
        s.seq  = seq_err;
        s.busy = busy;
        s.done = done;
        s.pass = pass;
        s.rdy  = vif.vec_ready;
        return s;
    endfunction

    task automatic model_clear(input int next_state);
        m_state = next_state;
        m_cnt   = '0;
        m_err   = '0;
        m_fev   = 1'b0;
        m_fei   = '0;
        m_seq   = 1'b0;
        m_pass  = 1'b0;
    endtask

    // One clock of stimulus: predict, push, clock, pop and compare.
    task automatic cycle(input logic v, input logic [IN_W-1:0] idx,
                         input logic [OUT_W-1:0] d, input logic [OUT_W-1:0] e,
                         input logic st, input string tag);
        snap_t want;
        snap_t got;
        logic  idx_bad;
        logic  fail;
        vif.vec_valid = v;
        vif.vec_idx   = idx;
        vif.dut_out   = d;
        vif.exp_out   = e;
        start         = st;
        if (st) begin
            model_clear(1);
        end else if (v && m_state == 1) begin
            idx_bad = (idx != m_cnt[IN_W-1:0]);
            fail    = idx_bad || (d != e);
            if (idx_bad) m_seq = 1'b1;
            if (fail) begin
                if (m_err != '1) m_err = m_err + 1'b1;
                if (!m_fev) begin
                    m_fev = 1'b1;
                    m_fei = idx;
                end
            end
            m_cnt = m_cnt + 1'b1;
            if (m_cnt == CNT_W'(NUM_CASES)) begin
                m_state = 2;
                m_pass  = (m_err == '0) && !m_seq;
            end
        end
        sb.push_back(model_snap());
        @(posedge clk);
        #1;
        vif.vec_valid = 1'b0;
        start         = 1'b0;
        want = sb.pop_front();
        got  = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic sweep(input logic [23:0] order, input logic [7:0] flip, input string tag);
        logic [IN_W-1:0]  idx;
        logic [OUT_W-1:0] e;
        for (int k = 0; k < NUM_CASES; k++) begin
            idx = order[3*k +: 3];
            e   = idx[1:0];
            cycle(1'b1, idx, flip[k] ? ~e : e, e, 1'b0, tag);
        end
    endtask

    // Asynchronous assertion away from any edge; outputs must clear at once.
    task automatic apply_reset(input string tag);
        snap_t got;
        rst = 1'b1;
        model_clear(0);
        #1;
        got = observed();
        total++;
        if (got !== model_snap()) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, model_snap());
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vif.vec_valid = 1'b0;
        vif.vec_idx   = '0;
        vif.dut_out   = '0;
        vif.exp_out   = '0;
        apply_reset("reset_state");
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b0, "idle_hold");
    endtask

    task automatic test_clean();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "clean_start");
        sweep(ORD_LIN, 8'h00, "clean_sweep");
        total++;
        if ({done, pass, case_count, err_count, first_err_valid} !== {1'b1, 1'b1, 4'd8, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL clean_verdict: got done=%b pass=%b cnt=%0d err=%0d fev=%b expected 1 1 8 0 0",
                     done, pass, case_count, err_count, first_err_valid);
        end
    endtask

    task automatic test_mismatch();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "mm_start");
        sweep(ORD_LIN, 8'b0100_1000, "mm_sweep");
        total++;
        if ({done, pass, err_count, first_err_valid, first_err_idx, seq_err} !==
            {1'b1, 1'b0, 4'd2, 1'b1, 3'd3, 1'b0}) begin
            bad++;
            $display("FAIL mm_verdict: got done=%b pass=%b err=%0d fev=%b fei=%0d seq=%b expected 1 0 2 1 3 0",
                     done, pass, err_count, first_err_valid, first_err_idx, seq_err);
        end
    endtask

    task automatic test_sequence();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "seq_start");
        sweep(ORD_SWAP, 8'h00, "seq_sweep");
        total++;
        if ({done, pass, err_count, first_err_idx, seq_err} !== {1'b1, 1'b0, 4'd2, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL seq_verdict: got done=%b pass=%b err=%0d fei=%0d seq=%b expected 1 0 2 4 1",
                     done, pass, err_count, first_err_idx, seq_err);
        end
    endtask

    task automatic test_gaps();
        apply_reset("gaps_reset");
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, "gaps_idle_valid");
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "gaps_start");
        for (int k = 0; k < NUM_CASES; k++) begin
            cycle(1'b1, 3'(k), 2'(k), 2'(k), 1'b0, "gaps_accept");
            cycle(1'b0, 3'(k + 1), 2'd0, 2'd3, 1'b0, "gaps_bubble");
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 2'd1, 2'd2, 1'b0, "gaps_done_valid");
        total++;
        if ({done, pass, case_count, err_count} !== {1'b1, 1'b1, 4'd8, 4'd0}) begin
            bad++;
            $display("FAIL gaps_verdict: got done=%b pass=%b cnt=%0d err=%0d expected 1 1 8 0",
                     done, pass, case_count, err_count);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "ar_start");
        for (int k = 0; k < 5; k++) cycle(1'b1, 3'(k), 2'(k), ~2'(k), 1'b0, "ar_accept");
        apply_reset("ar_midrun_reset");
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "ar_restart");
        sweep(ORD_LIN, 8'h00, "ar_sweep");
        total++;
        if ({done, pass} !== 2'b11) begin
            bad++;
            $display("FAIL ar_verdict: got done=%b pass=%b expected 1 1", done, pass);
        end
    endtask

    task automatic test_restart();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "rs_start");
        cycle(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, "rs_accept0");
        cycle(1'b1, 3'd1, 2'd2, 2'd1, 1'b0, "rs_accept1_bad");
        cycle(1'b1, 3'd2, 2'd2, 2'd2, 1'b0, "rs_accept2");
        cycle(1'b1, 3'd3, 2'd3, 2'd3, 1'b0, "rs_accept3");
        cycle(1'b1, 3'd4, 2'd1, 2'd2, 1'b1, "rs_start_with_valid");
        sweep(ORD_LIN, 8'h00, "rs_sweep");
        total++;
        if ({done, pass, err_count, first_err_valid} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL rs_verdict: got done=%b pass=%b err=%0d fev=%b expected 1 1 0 0",
                     done, pass, err_count, first_err_valid);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "b2b_start_a");
        sweep(ORD_LIN, 8'b1000_0000, "b2b_sweep_a");
        cycle(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, "b2b_start_b");
        sweep(ORD_LIN, 8'h00, "b2b_sweep_b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_mismatch();
        test_sequence();
        test_gaps();
        test_async_reset();
        test_restart();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
